// File: rtl/vga_pkg.sv
// Shared VGA timing constants, receive-side state encoding and a saturating
// counter helper for the sync-to-count recovery block.
package vga_pkg;

  localparam int DEFAULT_TOTAL_COLS  = 800;
  localparam int DEFAULT_TOTAL_ROWS  = 525;
  localparam int DEFAULT_ACTIVE_COLS = 640;
  localparam int DEFAULT_ACTIVE_ROWS = 480;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_SAT = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_SAT) begin
      result = CNT_SAT;
    end else begin
      result = value + 10'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Registered sync input stage: one-cycle delayed copies of HSync/VSync and
// rising-edge strobes formed from the live input against the delayed copy.
module vga_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_HSync,
  input  logic i_VSync,
  output logic o_HSync,
  output logic o_VSync,
  output logic o_H_Rise,
  output logic o_V_Rise
);

  logic hsync_r;
  logic vsync_r;

  // Capture the raw syncs; the registered copy doubles as the previous sample.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hsync_r <= 1'b0;
      vsync_r <= 1'b0;
    end else begin
      hsync_r <= i_HSync;
      vsync_r <= i_VSync;
    end
  end

  assign o_HSync  = hsync_r;
  assign o_VSync  = vsync_r;
  assign o_H_Rise = i_HSync & ~hsync_r;
  assign o_V_Rise = i_VSync & ~vsync_r;

endmodule

// File: rtl/vga_sync_to_count.sv
// Recovers column/row counts from active-high HSync/VSync, verifies line and
// frame timing against the configured totals, declares lock after a run of
// clean frames, pulses an error on violations and measures line length.
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int TOTAL_COLS  = DEFAULT_TOTAL_COLS,
  parameter int TOTAL_ROWS  = DEFAULT_TOTAL_ROWS,
  parameter int ACTIVE_COLS = DEFAULT_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEFAULT_ACTIVE_ROWS,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Frame_Start,
  output logic             o_Locked,
  output logic             o_Err,
  output logic [CNT_W-1:0] o_Line_Len
);

  // Active sizes are carried for downstream stages; only sanity-checked here.
  if ((ACTIVE_COLS > TOTAL_COLS) || (ACTIVE_ROWS > TOTAL_ROWS) ||
      (TOTAL_COLS < 2) || (TOTAL_COLS > 1024) ||
      (TOTAL_ROWS < 2) || (TOTAL_ROWS > 1024) ||
      (LOCK_FRAMES < 1) || (LOCK_FRAMES > 15)) begin : g_bad_params
    $error("vga_sync_to_count: inconsistent timing parameters");
  end

  localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_FRAMES);

  logic             h_rise_s;
  logic             v_rise_s;
  logic [CNT_W-1:0] col_r, col_s;
  logic [CNT_W-1:0] row_r, row_s;
  logic [CNT_W-1:0] row_inc_s;
  logic             at_line_end_s;
  logic             at_last_row_s;
  logic             timing_err_s;
  sync_state_e      state_r, state_s;
  logic [3:0]       good_r, good_s;
  logic             locked_r, locked_s;
  logic             err_r;
  logic             frame_start_r;
  logic [CNT_W-1:0] len_r, len_s;
  logic [CNT_W-1:0] line_len_r, line_len_s;

  vga_edge_detect u_edge (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_HSync  (i_HSync),
    .i_VSync  (i_VSync),
    .o_HSync  (o_HSync),
    .o_VSync  (o_VSync),
    .o_H_Rise (h_rise_s),
    .o_V_Rise (v_rise_s)
  );

  assign at_line_end_s = (col_r == COL_LAST);
  assign at_last_row_s = (row_r == ROW_LAST);
  assign row_inc_s     = at_last_row_s ? 10'd0 : (row_r + 10'd1);

  // Next counts: VSync rise homes to (0,0), HSync rise starts a new line, else free-run.
  always_comb begin
    col_s = col_r;
    row_s = row_r;
    if (v_rise_s) begin
      col_s = 10'd0;
      row_s = 10'd0;
    end else if (h_rise_s) begin
      col_s = 10'd0;
      row_s = row_inc_s;
    end else if (at_line_end_s) begin
      col_s = 10'd0;
      row_s = row_inc_s;
    end else begin
      col_s = col_r + 10'd1;
      row_s = row_r;
    end
  end

  // Timing violations judged on pre-update counts, only once a frame start was seen.
  always_comb begin
    timing_err_s = 1'b0;
    if (state_r != SEARCH) begin
      timing_err_s = (v_rise_s & ~(at_last_row_s & at_line_end_s))   // frame length
                   | (h_rise_s & ~v_rise_s & ~at_line_end_s)         // line length
                   | (h_rise_s & ~v_rise_s & at_last_row_s)          // VSync missing
                   | (at_line_end_s & ~h_rise_s & ~v_rise_s);        // HSync missing
    end else begin
      timing_err_s = 1'b0;
    end
  end

  // Lock FSM next state: any error drops to SEARCH, clean frame starts build toward lock.
  always_comb begin
    state_s  = state_r;
    good_s   = good_r;
    locked_s = locked_r;
    case (state_r)
      SEARCH: begin
        if (v_rise_s) begin
          state_s = VERIFY;
          good_s  = 4'd0;
        end else begin
          state_s = SEARCH;
        end
      end
      VERIFY: begin
        if (timing_err_s) begin
          state_s  = SEARCH;
          good_s   = 4'd0;
          locked_s = 1'b0;
        end else if (v_rise_s) begin
          good_s = good_r + 4'd1;
          if ((good_r + 4'd1) == LOCK_TARGET) begin
            state_s  = LOCKED;
            locked_s = 1'b1;
          end else begin
            state_s = VERIFY;
          end
        end else begin
          state_s = VERIFY;
        end
      end
      LOCKED: begin
        if (timing_err_s) begin
          state_s  = SEARCH;
          good_s   = 4'd0;
          locked_s = 1'b0;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s  = SEARCH;
        good_s   = 4'd0;
        locked_s = 1'b0;
      end
    endcase
  end

  // Line length: running count since the last HSync rise, latched on each rise.
  always_comb begin
    len_s      = sat_inc(len_r);
    line_len_s = line_len_r;
    if (h_rise_s) begin
      len_s      = 10'd0;
      line_len_s = sat_inc(len_r);
    end else begin
      line_len_s = line_len_r;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r  <= SEARCH;
      good_r   <= 4'd0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      good_r   <= good_s;
      locked_r <= locked_s;
    end
  end

  // Counter, pulse and line-length registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      col_r         <= 10'd0;
      row_r         <= 10'd0;
      frame_start_r <= 1'b0;
      err_r         <= 1'b0;
      len_r         <= 10'd0;
      line_len_r    <= 10'd0;
    end else begin
      col_r         <= col_s;
      row_r         <= row_s;
      frame_start_r <= v_rise_s;
      err_r         <= timing_err_s;
      len_r         <= len_s;
      line_len_r    <= line_len_s;
    end
  end

  assign o_Col_Count   = col_r;
  assign o_Row_Count   = row_r;
  assign o_Frame_Start = frame_start_r;
  assign o_Locked      = locked_r;
  assign o_Err         = err_r;
  assign o_Line_Len    = line_len_r;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Self-checking bench for vga_sync_to_count using a reduced 24x10 raster so
// that many frames fit in a short run.
module tb_vga_sync_to_count;

  localparam int TC = 24;
  localparam int TR = 10;
  localparam int AC = 16;
  localparam int AR = 6;
  localparam int LF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b0;
  logic       vs = 1'b0;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Err;
  logic [9:0] o_Col_Count, o_Row_Count, o_Line_Len;

  vga_sync_to_count #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_HSync(hs), .i_VSync(vs),
    .o_HSync(o_HSync), .o_VSync(o_VSync),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count),
    .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked), .o_Err(o_Err),
    .o_Line_Len(o_Line_Len)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raster position, lock progress, line length
  int m_hs, m_vs, m_col, m_row, m_fs, m_lock, m_err, m_len, m_linelen;
  int m_state;   // 0 searching, 1 verifying, 2 locked
  int m_good;

  // Generator and bookkeeping
  int g_col = 0, g_row = 0, g_cols = TC;
  int a_col, a_row;
  int fs_cnt = 0, err_cnt = 0, lock_fs = 0;
  bit locked_seen = 1'b0;
  bit align_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hs = 0; m_vs = 0; m_col = 0; m_row = 0; m_fs = 0; m_lock = 0; m_err = 0;
    m_len = 0; m_linelen = 0; m_state = 0; m_good = 0;
  endtask

  // One pixel clock of the specification's rules applied to the sampled inputs.
  task automatic model_step(input bit h, input bit v);
    bit hr, vr, bad;
    bit end_of_line, last_row;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hr = h && (m_hs == 0);
    vr = v && (m_vs == 0);
    end_of_line = (m_col == TC - 1);
    last_row    = (m_row == TR - 1);
    bad = 1'b0;
    if (m_state != 0) begin
      if (vr && !(last_row && end_of_line)) bad = 1'b1;
      if (hr && !vr && (!end_of_line || last_row)) bad = 1'b1;
      if (!hr && !vr && end_of_line) bad = 1'b1;
    end
    if (vr) begin
      m_col = 0; m_row = 0;
    end else if (hr) begin
      m_col = 0; m_row = (m_row + 1) % TR;
    end else begin
      m_col = (m_col + 1) % TC;
      if (m_col == 0) m_row = (m_row + 1) % TR;
    end
    m_fs  = vr;
    m_err = bad;
    if (bad) begin
      m_state = 0; m_good = 0; m_lock = 0;
    end else if (vr && m_state == 0) begin
      m_state = 1; m_good = 0;
    end else if (vr && m_state == 1) begin
      m_good++;
      if (m_good == LF) begin m_state = 2; m_lock = 1; end
    end
    if (hr) begin
      m_linelen = (m_len + 1 > 1023) ? 1023 : m_len + 1;
      m_len = 0;
    end else begin
      m_len = (m_len + 1 > 1023) ? 1023 : m_len + 1;
    end
    m_hs = h; m_vs = v;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("o_HSync", int'(o_HSync), m_hs);
    chk("o_VSync", int'(o_VSync), m_vs);
    chk("o_Col_Count", int'(o_Col_Count), m_col);
    chk("o_Row_Count", int'(o_Row_Count), m_row);
    chk("o_Frame_Start", int'(o_Frame_Start), m_fs);
    chk("o_Locked", int'(o_Locked), m_lock);
    chk("o_Err", int'(o_Err), m_err);
    chk("o_Line_Len", int'(o_Line_Len), m_linelen);
  end

  task automatic tick(input bit h, input bit v);
    hs = h; vs = v;
    @(posedge clk);
    model_step(h, v);
    @(negedge clk);
    if (o_Frame_Start) fs_cnt++;
    if (o_Err) err_cnt++;
    if (o_Locked && !locked_seen) begin locked_seen = 1'b1; lock_fs = fs_cnt; end
  endtask

  task automatic gen_tick(input bit force_h);
    bit h, v;
    h = (g_col < AC) || force_h;
    v = (g_row < AR);
    a_col = g_col; a_row = g_row;
    tick(h, v);
    if (align_en) begin
      chk("align_col", int'(o_Col_Count), a_col);
      chk("align_row", int'(o_Row_Count), a_row);
    end
    g_col++;
    if (g_col == g_cols) begin g_col = 0; g_row = (g_row + 1) % TR; end
  endtask

  task automatic run_frames(input int n);
    repeat (n * g_cols * TR) gen_tick(1'b0);
  endtask

  task automatic run_until(input int r, input int c);
    for (int i = 0; i < 5000; i++) begin
      if (g_row == r && g_col == c) break;
      gen_tick(1'b0);
    end
    chk("reach_position", int'(g_row == r && g_col == c), 1);
  endtask

  task automatic restart_lock_tracking();
    fs_cnt = 0; locked_seen = 1'b0; lock_fs = 0; err_cnt = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fc, sr;
    model_reset();
    // Reset state
    repeat (3) tick(1'b0, 1'b0);
    chk("rst_col", int'(o_Col_Count), 0);
    chk("rst_row", int'(o_Row_Count), 0);
    chk("rst_locked", int'(o_Locked), 0);
    chk("rst_line_len", int'(o_Line_Len), 0);
    rst_n = 1'b1;

    // Free-run with idle inputs
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 1'b0);
      chk("freerun_col", int'(o_Col_Count), k);
      chk("freerun_err", int'(o_Err), 0);
    end

    // Clean raster: lock on the third frame start, line length = TC
    g_col = 0; g_row = 0; g_cols = TC;
    restart_lock_tracking();
    align_en = 1'b1;
    run_frames(4);
    align_en = 1'b0;
    chk("lock_on_3rd_fs", lock_fs, 3);
    chk("locked_clean", int'(o_Locked), 1);
    chk("line_len_clean", int'(o_Line_Len), TC);
    chk("no_err_clean", err_cnt, 0);

    // Early HSync rise inside blanking
    fc = $urandom_range(AC + 1, TC - 2);
    run_until(3, fc);
    err_cnt = 0;
    gen_tick(1'b1);
    chk("early_h_err", int'(o_Err), 1);
    chk("early_h_unlock", int'(o_Locked), 0);
    chk("early_h_col0", int'(o_Col_Count), 0);
    run_until(0, 0);
    fs_cnt = 0; locked_seen = 1'b0;
    run_frames(3);
    chk("early_h_relock_fs", lock_fs, 3);
    chk("early_h_err_count", err_cnt, 1);

    // Missing HSync pulse: hold high through blanking
    sr = $urandom_range(1, TR - 3);
    run_until(sr, AC);
    err_cnt = 0;
    repeat (TC - AC) gen_tick(1'b1);
    gen_tick(1'b0);
    chk("miss_h_err", int'(o_Err), 1);
    chk("miss_h_unlock", int'(o_Locked), 0);
    chk("miss_h_col", int'(o_Col_Count), 0);
    chk("miss_h_row", int'(o_Row_Count), sr + 1);
    align_en = 1'b1;
    run_until(0, 0);
    fs_cnt = 0; locked_seen = 1'b0;
    run_frames(3);
    align_en = 1'b0;
    chk("miss_h_relock_fs", lock_fs, 3);
    chk("miss_h_err_count", err_cnt, 1);

    // Short lines (TC-1 clocks): never locks
    g_cols = TC - 1;
    repeat (TC) gen_tick(1'b0);
    restart_lock_tracking();
    run_until(0, 0);
    run_frames(3);
    chk("short_never_lock", int'(locked_seen), 0);
    chk("short_line_len", int'(o_Line_Len), TC - 1);
    chk("short_errors_seen", int'(err_cnt >= 3), 1);
    g_cols = TC;

    // Reset in mid-frame, then relock
    run_frames(4);
    chk("pre_reset_locked", int'(o_Locked), 1);
    run_until(5, 10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_col", int'(o_Col_Count), 0);
    chk("async_rst_row", int'(o_Row_Count), 0);
    chk("async_rst_locked", int'(o_Locked), 0);
    chk("async_rst_vsync", int'(o_VSync), 0);
    chk("async_rst_line_len", int'(o_Line_Len), 0);
    repeat (3) gen_tick(1'b0);
    rst_n = 1'b1;
    restart_lock_tracking();
    gen_tick(1'b0);
    chk("first_sample_vrise", int'(o_Frame_Start), 1);
    run_until(0, 0);
    run_frames(4);
    chk("relock_after_reset", int'(o_Locked), 1);
    chk("post_reset_err_count", err_cnt, 1);

    // Line length measurement and saturation
    tick(1'b1, 1'b0);
    repeat (799) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("line_len_800", int'(o_Line_Len), 800);
    repeat (1021) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("line_len_1022", int'(o_Line_Len), 1022);
    repeat (1099) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("line_len_sat", int'(o_Line_Len), 1023);

    // Raster with random HSync glitches
    g_col = 0; g_row = 0; g_cols = TC;
    repeat (6 * TC * TR) gen_tick($urandom_range(0, 199) == 0);

    // Unstructured random sync activity
    repeat (2000) tick($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
